// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator and its DAC121S101 serialiser:
// waveform codes, DAC frame layout and default phase constants.
package tone_pkg;

   typedef enum logic [1:0] {
      WAVE_SQUARE = 2'b00,
      WAVE_SAW    = 2'b01,
      WAVE_TRI    = 2'b10,
      WAVE_SILENT = 2'b11
   } wave_e;

   localparam logic [11:0] MIDSCALE        = 12'd2048;
   localparam logic [13:0] FMAX            = 14'd9999;
   localparam logic [1:0]  DAC_PAD         = 2'b00;
   localparam logic [1:0]  DAC_PD_NORMAL   = 2'b00;
   localparam int          PHASE_K_DEFAULT = 214748;

   // DAC121S101 word: two don't-care bits, power-down mode, then the sample.
   function automatic logic [15:0] dac_frame(input logic [11:0] sample);
      return {DAC_PAD, DAC_PD_NORMAL, sample};
   endfunction

endpackage

// File: rtl/dac121_spi_tx.sv
// Write-only SPI serialiser for one 16-bit DAC121S101 frame: SYNC low for the
// whole frame, SCLK idles high, DIN changes on SCLK rise, DAC samples on fall.
module dac121_spi_tx
   import tone_pkg::*;
#(
   parameter int SCLK_DIV = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [11:0] word_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        sync_o,
   output logic        sclk_o,
   output logic        din_o
);

   localparam int DIV_W = $clog2(2 * SCLK_DIV);
   localparam logic [DIV_W-1:0] DIV_FALL = DIV_W'(SCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCLK_DIV - 1);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

   state_e           state_q;
   logic [DIV_W-1:0] div_q;
   logic [3:0]       bit_q;
   logic [15:0]      shreg_q;
   logic             busy_q;
   logic             done_q;
   logic             sync_q;
   logic             sclk_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sync_q  <= 1'b1;
         sclk_q  <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  shreg_q <= dac_frame(word_i);
                  sync_q  <= 1'b0;
                  sclk_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  div_q   <= '0;
                  bit_q   <= 4'd15;
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (div_q == DIV_FALL) begin
                  sclk_q <= 1'b0;
                  div_q  <= div_q + 1'b1;
               end else if (div_q == DIV_LAST) begin
                  div_q  <= '0;
                  sclk_q <= 1'b1;
                  if (bit_q == 4'd0) begin
                     // SYNC and SCLK rise together after the last low phase.
                     sync_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     shreg_q <= '0;
                     state_q <= ST_IDLE;
                  end else begin
                     bit_q   <= bit_q - 1'b1;
                     shreg_q <= {shreg_q[14:0], 1'b0};
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign sync_o = sync_q;
   assign sclk_o = sclk_q;
   assign din_o  = shreg_q[15];

endmodule

// File: rtl/tone_dac_tx.sv
// Tone synthesiser for the Pmod DA2: a sample tick drives a 32-bit phase
// accumulator and waveform mux, and each sample is sent as one DAC frame.
module tone_dac_tx
   import tone_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int SAMPLE_HZ = 20_000,
   parameter int SCLK_DIV  = 4,
   parameter int PHASE_K   = PHASE_K_DEFAULT
) (
   input  logic        CLK100MHZ,
   input  logic        RESETN,
   input  logic [13:0] freq_hz,
   input  logic [1:0]  wave_sel,
   output logic        DA_SYNC,
   output logic        DA_SCLK,
   output logic        DA_DIN,
   output logic [11:0] level,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
   localparam int CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   // A whole frame plus the restart cycles must fit between two ticks.
   if (32 * SCLK_DIV + 2 >= TICK_DIV) begin : g_rate_check
      $error("tone_dac_tx: DAC frame does not fit in one sample period");
   end

   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      phase_q;
   logic [31:0]      phase_d;
   logic [11:0]      level_q;
   logic             overrun_q;

   logic             tick;
   logic             start;
   logic             tx_busy;
   logic [13:0]      f_clamp;
   wave_e            wave;
   logic             silent;
   logic [11:0]      sample;

   assign tick  = (cnt_q == TICK_LAST);
   assign start = tick & ~tx_busy;

   always_comb begin
      f_clamp = (freq_hz > FMAX) ? FMAX : freq_hz;
      wave    = wave_e'(wave_sel);
      silent  = (wave == WAVE_SILENT) || (f_clamp == 14'd0);
      sample  = MIDSCALE;
      if (!silent) begin
         case (wave)
            WAVE_SQUARE: sample = phase_q[31] ? 12'd0 : 12'hFFF;
            WAVE_SAW:    sample = phase_q[31:20];
            WAVE_TRI:    sample = phase_q[31] ? ~phase_q[30:19] : phase_q[30:19];
            default:     sample = MIDSCALE;
         endcase
      end
      // Silence parks the phase so the next tone always starts from zero.
      phase_d = silent ? 32'd0 : phase_q + 32'(f_clamp) * 32'(PHASE_K);
   end

   always_ff @(posedge CLK100MHZ or negedge RESETN) begin
      if (!RESETN) begin
         cnt_q     <= '0;
         phase_q   <= '0;
         level_q   <= MIDSCALE;
         overrun_q <= 1'b0;
      end else begin
         cnt_q <= tick ? '0 : cnt_q + 1'b1;
         if (tick) begin
            phase_q <= phase_d;
            if (tx_busy) begin
               overrun_q <= 1'b1;
            end else begin
               level_q <= sample;
            end
         end
      end
   end

   dac121_spi_tx #(
      .SCLK_DIV (SCLK_DIV)
   ) u_spi (
      .clk_i   (CLK100MHZ),
      .rst_ni  (RESETN),
      .start_i (start),
      .word_i  (sample),
      .busy_o  (tx_busy),
      .done_o  (frame_done),
      .sync_o  (DA_SYNC),
      .sclk_o  (DA_SCLK),
      .din_o   (DA_DIN)
   );

   assign busy    = tx_busy;
   assign level   = level_q;
   assign overrun = overrun_q;

endmodule
